// File: rtl/phy_dly_pkg.sv
// Shared definitions for the byte-lane delay-programming path: emitted
// address window and the table-loader state encoding.
package phy_dly_pkg;

  localparam int unsigned DLY_ODLY_FIRST       = 0;
  localparam int unsigned DLY_ODLY_LAST        = 9;
  localparam int unsigned DLY_IDLY_FIRST       = 16;
  localparam int unsigned DLY_IDLY_LAST        = 24;
  localparam int unsigned DLY_ENTRIES_PER_LANE = 19;

  typedef enum logic [2:0] {IDLE, LOAD, SET, SETTLE, DONE} dly_ld_state_t;

  // Entry index k (0..18) to delay address: ODELAYs first, then IDELAYs.
  function automatic logic [4:0] dly_entry_addr(input logic [4:0] k);
    if (k <= 5'(DLY_ODLY_LAST)) return k;
    return k + 5'(DLY_IDLY_FIRST - DLY_ODLY_LAST - 1);
  endfunction

endpackage

// File: rtl/dly_entry_seq.sv
// Lane/entry walker for the delay table loader. Its outputs describe the entry
// that will be current after this edge, so the parent can emit it in the same cycle.
module dly_entry_seq
  import phy_dly_pkg::*;
#(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned LW        = 1
) (
  input  logic                 clk_div,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_adv,
  input  logic [NUM_LANES-1:0] i_mask,
  output logic [LW-1:0]        o_lane,
  output logic [4:0]           o_addr,
  output logic                 o_last,
  output logic                 o_none
);

  logic [LW-1:0]        r_lane, w_lane;
  logic [4:0]           r_k, w_k;
  logic [NUM_LANES-1:0] r_mask, w_mask;
  logic [LW:0]          w_first, w_after_r, w_after_n;

  // Lowest masked lane at or above 'from'; NUM_LANES when there is none.
  function automatic logic [LW:0] find_lane(input logic [NUM_LANES-1:0] m,
                                             input logic [LW:0] from);
    logic [LW:0] res;
    logic        found;
    res   = (LW+1)'(NUM_LANES);
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (!found && m[LW'(i)] && ((LW+1)'(i) >= from)) begin
        res   = (LW+1)'(i);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign w_first   = find_lane(i_mask, '0);
  assign o_none    = (w_first == (LW+1)'(NUM_LANES));
  assign w_after_r = find_lane(r_mask, {1'b0, r_lane} + (LW+1)'(1));

  always_comb begin
    w_lane = r_lane;
    w_k    = r_k;
    w_mask = r_mask;
    if (i_load) begin
      w_mask = i_mask;
      w_lane = w_first[LW-1:0];
      w_k    = '0;
    end else if (i_adv) begin
      if (r_k == 5'(DLY_ENTRIES_PER_LANE - 1)) begin
        w_k    = '0;
        w_lane = w_after_r[LW-1:0];
      end else begin
        w_k = r_k + 5'd1;
      end
    end
  end

  assign w_after_n = find_lane(w_mask, {1'b0, w_lane} + (LW+1)'(1));
  assign o_lane    = w_lane;
  assign o_addr    = dly_entry_addr(w_k);
  assign o_last    = (w_k == 5'(DLY_ENTRIES_PER_LANE - 1)) &&
                     (w_after_n == (LW+1)'(NUM_LANES));

  always_ff @(posedge clk_div) begin
    if (rst) begin
      r_lane <= '0;
      r_k    <= '0;
      r_mask <= '0;
    end else begin
      r_lane <= w_lane;
      r_k    <= w_k;
      r_mask <= w_mask;
    end
  end

endmodule

// File: rtl/dly_table_loader.sv
// Delay-table loader: host-written per-lane tap table streamed to byte lanes
// via ld_delay, then one shared set. Optional readback: DLY_TABLE_LOADER_READBACK_EN.
module dly_table_loader
  import phy_dly_pkg::*;
#(
  parameter  int unsigned NUM_LANES     = 2,
  parameter  int unsigned SETTLE_CYCLES = 4,
  localparam int unsigned LW            = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk_div,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [LW+4:0]        wr_addr,
  input  logic [7:0]           wr_data,
`ifdef DLY_TABLE_LOADER_READBACK_EN
  input  logic [LW+4:0]        rd_addr,
  output logic [7:0]           rd_data,
`endif
  input  logic [NUM_LANES-1:0] lane_mask,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           dly_data,
  output logic [4:0]           dly_addr,
  output logic [NUM_LANES-1:0] ld_delay,
  output logic                 set
);

  localparam int unsigned DEPTH       = (1 << LW) * 32;
  localparam logic [7:0]  SETTLE_LAST = 8'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  logic [7:0]    r_table [DEPTH];
  dly_ld_state_t r_state, w_state;
  logic [7:0]    r_settle_cnt;
  logic          r_last;
  logic          w_load, w_adv, w_emit;
  logic [LW-1:0] w_seq_lane;
  logic [4:0]    w_seq_addr;
  logic          w_seq_last, w_seq_none;

  dly_entry_seq #(
    .NUM_LANES (NUM_LANES),
    .LW        (LW)
  ) u_seq (
    .clk_div (clk_div),
    .rst     (rst),
    .i_load  (w_load),
    .i_adv   (w_adv),
    .i_mask  (lane_mask),
    .o_lane  (w_seq_lane),
    .o_addr  (w_seq_addr),
    .o_last  (w_seq_last),
    .o_none  (w_seq_none)
  );

  always_ff @(posedge clk_div) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_table[(LW+5)'(i)] <= '0;
    end else if (wr_en) begin
      r_table[wr_addr] <= wr_data;
    end
  end

`ifdef DLY_TABLE_LOADER_READBACK_EN
  always_ff @(posedge clk_div) begin
    if (rst) rd_data <= '0;
    else     rd_data <= r_table[rd_addr];
  end
`endif

  always_comb begin
    w_state = r_state;
    w_load  = 1'b0;
    w_adv   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load  = 1'b1;
          w_state = w_seq_none ? SET : LOAD;
        end
      end
      LOAD: begin
        if (r_last) w_state = SET;
        else        w_adv   = 1'b1;
      end
      SET:     w_state = (SETTLE_CYCLES == 0) ? DONE : SETTLE;
      SETTLE:  if (r_settle_cnt == SETTLE_LAST) w_state = DONE;
      DONE:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  // The first entry is emitted on the accepting edge so ld pulses start in cycle 1.
  assign w_emit = (w_load && !w_seq_none) || w_adv;

  always_ff @(posedge clk_div) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state;
  end

  always_ff @(posedge clk_div) begin
    if (rst || (r_state != SETTLE)) r_settle_cnt <= '0;
    else                            r_settle_cnt <= r_settle_cnt + 8'd1;
  end

  always_ff @(posedge clk_div) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      set      <= 1'b0;
      ld_delay <= '0;
      dly_addr <= '0;
      dly_data <= '0;
      r_last   <= 1'b0;
    end else begin
      busy <= (w_state == LOAD) || (w_state == SET) || (w_state == SETTLE);
      set  <= (w_state == SET);
      done <= (w_state == DONE);
      if (w_emit) begin
        ld_delay <= NUM_LANES'(1) << w_seq_lane;
        dly_addr <= w_seq_addr;
        dly_data <= r_table[{w_seq_lane, w_seq_addr}];
        r_last   <= w_seq_last;
      end else begin
        ld_delay <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dly_table_loader.sv
// Self-checking bench for dly_table_loader (NUM_LANES=2, SETTLE_CYCLES=4) with a
// cycle-level schedule model; readback checks under DLY_TABLE_LOADER_READBACK_EN.
module tb_dly_table_loader;

  localparam int S = 4;

  logic       clk_div = 1'b0;
  logic       rst = 1'b0, wr_en = 1'b0, start = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [1:0] lane_mask = '0;
  logic       busy, done, set;
  logic [7:0] dly_data;
  logic [4:0] dly_addr;
  logic [1:0] ld_delay;
`ifdef DLY_TABLE_LOADER_READBACK_EN
  logic [5:0] rd_addr = '0;
  logic [7:0] rd_data;
`endif

  dly_table_loader #(.NUM_LANES(2), .SETTLE_CYCLES(S)) dut (
    .clk_div   (clk_div),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`ifdef DLY_TABLE_LOADER_READBACK_EN
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
`endif
    .lane_mask (lane_mask),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .dly_data  (dly_data),
    .dly_addr  (dly_addr),
    .ld_delay  (ld_delay),
    .set       (set)
  );

  always #5 clk_div = ~clk_div;

  int n_cmp = 0, n_fail = 0;

  // Reference model state
  logic [7:0] tbl [64];
  bit         running = 0, chk_en = 0;
  int         r = 0, M = 0;
  int         lanes[$];
  logic [1:0] e_ld = '0;
  logic       e_set = 0, e_done = 0, e_busy = 0;
  logic [4:0] e_addr = '0;
  logic [7:0] e_data = '0;

  // Observations of DUT behaviour relative to the last accepted start
  int         cyc = 0, t0 = 0, ld_cnt = 0, set_at = -1, done_at = -1, done_cnt = 0;
  logic [7:0] d_at1 = '0, d_at6 = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_obs();
    ld_cnt = 0; set_at = -1; done_at = -1; done_cnt = 0;
  endtask

  task automatic step(input bit we, input logic [5:0] wa, input logic [7:0] wd,
                      input logic [1:0] m, input bit st, input bit rs);
    int rn, tot, e, k, a, ln;
    bit act;
    @(negedge clk_div);
    if (chk_en) begin
      chk("ld_delay", 32'(ld_delay), 32'(e_ld));
      chk("set", 32'(set), 32'(e_set));
      chk("done", 32'(done), 32'(e_done));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("dly_addr", 32'(dly_addr), 32'(e_addr));
      chk("dly_data", 32'(dly_data), 32'(e_data));
      ld_cnt += $countones(ld_delay);
      if (set === 1'b1) set_at = cyc - t0;
      if (done === 1'b1) begin done_at = cyc - t0; done_cnt++; end
      if (cyc - t0 == 1) d_at1 = dly_data;
      if (cyc - t0 == 6) d_at6 = dly_data;
    end
    rst = rs; wr_en = we; wr_addr = wa; wr_data = wd; lane_mask = m; start = st;
    if (rs) begin
      e_ld = '0; e_set = 0; e_done = 0; e_busy = 0; e_addr = '0; e_data = '0;
      running = 0; r = 0;
      for (int i = 0; i < 64; i++) tbl[i] = '0;
      chk_en = 1;
    end else begin
      act = 0; rn = 0;
      tot = 19 * M + 2 + S;
      if (running) begin
        if (r < tot) begin act = 1; rn = r + 1; end
      end else if (st) begin
        lanes.delete();
        if (m[0]) lanes.push_back(0);
        if (m[1]) lanes.push_back(1);
        M = lanes.size();
        tot = 19 * M + 2 + S;
        act = 1; rn = 1; t0 = cyc;
      end
      e_ld = '0; e_set = 0; e_done = 0; e_busy = 0;
      if (act) begin
        if (rn <= 19 * M) begin
          e  = rn - 1;
          k  = e % 19;
          a  = (k < 10) ? k : k + 6;
          ln = lanes[e / 19];
          e_ld   = 2'(1 << ln);
          e_addr = 5'(a);
          e_data = tbl[6'(ln * 32 + a)];
        end
        e_set  = (rn == 19 * M + 1);
        e_done = (rn == tot);
        e_busy = (rn < tot);
      end
      running = act; r = rn;
      if (we) tbl[wa] = wd;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, 0);
  endtask

  initial begin
    logic [7:0] pat, old;
    logic [5:0] wa;
    step(0, '0, '0, '0, 0, 1);
    step(0, '0, '0, '0, 0, 1);
    idle(2);

    // Fill: valid entries get {lane, addr, 2'b01}; unemitted addresses get noise
    for (int ln = 0; ln < 2; ln++) begin
      for (int a = 0; a < 32; a++) begin
        wa  = 6'(ln * 32 + a);
        pat = {wa, 2'b01};
        if ((a > 9 && a < 16) || a > 24) pat = 8'($urandom);
        step(1, wa, pat, '0, 0, 0);
      end
    end
    idle(2);

    clr_obs(); step(0, '0, '0, 2'b11, 1, 0); idle(50);
    chk("both_ld_count", 32'(ld_cnt), 32'd38);
    chk("both_set_cycle", 32'(set_at), 32'd39);
    chk("both_done_cycle", 32'(done_at), 32'd44);

    clr_obs(); step(0, '0, '0, 2'b10, 1, 0); idle(30);
    chk("lane1_ld_count", 32'(ld_cnt), 32'd19);
    chk("lane1_set_cycle", 32'(set_at), 32'd20);
    chk("lane1_done_cycle", 32'(done_at), 32'd25);

    clr_obs(); step(0, '0, '0, 2'b00, 1, 0); idle(10);
    chk("nomask_ld_count", 32'(ld_cnt), 32'd0);
    chk("nomask_set_cycle", 32'(set_at), 32'd1);
    chk("nomask_done_cycle", 32'(done_at), 32'd6);

    // Writes landing mid-run: later entry sees new data, already-emitted one does not
    clr_obs(); step(0, '0, '0, 2'b01, 1, 0); idle(2);
    step(1, 6'd5, 8'hAA, '0, 0, 0);
    step(1, 6'd0, 8'h55, '0, 0, 0);
    idle(30);
    chk("midwrite_entry6", 32'(d_at6), 32'hAA);
    chk("midwrite_entry1", 32'(d_at1), 32'h01);

    // Reset at cycle 10 aborts; the table is cleared
    step(0, '0, '0, 2'b11, 1, 0); idle(9);
    step(0, '0, '0, '0, 0, 1);
    clr_obs(); idle(45);
    chk("abort_ld_count", 32'(ld_cnt), 32'd0);
    chk("abort_set", 32'(set_at), 32'hFFFF_FFFF);
    chk("abort_done", 32'(done_at), 32'hFFFF_FFFF);
    clr_obs(); step(0, '0, '0, 2'b11, 1, 0); idle(50);
    chk("zero_ld_count", 32'(ld_cnt), 32'd38);

    // Second start while busy is dropped
    clr_obs(); step(0, '0, '0, 2'b01, 1, 0); idle(4);
    step(0, '0, '0, 2'b11, 1, 0); idle(40);
    chk("restart_ld_count", 32'(ld_cnt), 32'd19);
    chk("restart_done_count", 32'(done_cnt), 32'd1);

    // Start coinciding with reset: reset wins
    step(0, '0, '0, 2'b11, 1, 1); clr_obs(); idle(5);
    chk("rst_start_busy", 32'(ld_cnt), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step(bit'($urandom_range(1)), 6'($urandom), 8'($urandom), 2'($urandom),
           ($urandom_range(7) == 0), ($urandom_range(199) == 0));
    idle(50);

`ifdef DLY_TABLE_LOADER_READBACK_EN
    step(1, 6'd49, 8'h3C, '0, 0, 0);
    idle(1);
    rd_addr = 6'd49;
    idle(1);
    chk("readback_3c", 32'(rd_data), 32'h3C);
    old = tbl[3];
    rd_addr = 6'd3;
    step(1, 6'd3, ~old, '0, 0, 0);
    idle(1);
    chk("readback_old", 32'(rd_data), 32'(old));
    idle(1);
    chk("readback_new", 32'(rd_data), 32'(~old));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
